gpio_cfg_loader: RTL and testbench



---
 rtl/gpio_cfg_loader.sv | 211 +++++++++++++++++++++
 tb/tb_gpio_cfg_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_loader.sv
// GPIO pad-control chain loader: per-pad shadow registers, serial shift of all pads,
// load strobe, and an optional second pass that checks the bits returned from the chain tail.
module gpio_cfg_loader #(
    parameter int                         NUM_PADS      = 9,
    parameter int                         PAD_CTRL_BITS = 12,
    parameter logic [PAD_CTRL_BITS-1:0]   GPIO_DEFAULTS = 12'hC00,
    parameter int                         CLK_DIV       = 2,
    parameter int                         AUTO_LOAD     = 1,
    localparam int                        IW            = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                     mclk,
    input  logic                     resetn,
    input  logic                     cfg_wr_en,
    input  logic [IW-1:0]            cfg_wr_idx,
    input  logic [PAD_CTRL_BITS-1:0] cfg_wr_data,
    input  logic [IW-1:0]            cfg_rd_idx,
    output logic [PAD_CTRL_BITS-1:0] cfg_rd_data,
    input  logic                     start,
    input  logic                     verify,
    output logic                     busy,
    output logic                     done,
    output logic                     verify_err,
    output logic [7:0]               err_cnt,
    output logic                     serial_clock,
    output logic                     serial_load,
    output logic                     serial_data_out,
    input  logic                     serial_data_in
);

    // state  | meaning
    // IDLE   | waiting for start; shadow writes allowed
    // LO     | serial_clock low, data bit k presented (pass 2: tail sampled at end)
    // HI     | serial_clock high, data held
    // LOAD   | serial_load strobe, chain latches
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_LOAD, S_DONE} state_t;

    localparam int L  = NUM_PADS * PAD_CTRL_BITS;
    localparam int KW = (L > 1) ? $clog2(L) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(L - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [PAD_CTRL_BITS-1:0]   r_shadow [NUM_PADS];
    logic [KW-1:0]              r_k;
    logic [DW-1:0]              r_div;
    logic                       r_pass;
    logic                       r_vmode;
    logic                       r_auto_pend;
    logic                       r_verify_err;
    logic [7:0]                 r_err_cnt;

    logic                       w_accept;
    logic                       w_accept_verify;
    logic                       w_div_tc;
    logic                       w_last_bit;
    logic                       w_more_pass;
    logic [L-1:0]               w_flat;
    logic [KW-1:0]              w_sidx;
    logic                       w_stream_bit;
    logic                       w_wr_ok;
    logic                       w_sclk;
    logic                       w_sload;
    logic                       w_sdo;
    logic                       w_busy;
    logic                       w_done;
    logic [PAD_CTRL_BITS-1:0]   w_rd_data;

    // Auto-load behaves as a start with verify forced off.
    assign w_accept        = (r_state == S_IDLE) && (start || r_auto_pend);
    assign w_accept_verify = r_auto_pend ? 1'b0 : verify;
    assign w_div_tc        = (r_div == '0);
    assign w_last_bit      = (r_k == K_LAST);
    assign w_more_pass     = r_vmode && (r_pass == 1'b0);
    assign w_wr_ok         = cfg_wr_en && (r_state == S_IDLE) && (int'(cfg_wr_idx) < NUM_PADS);

    // Flattened so pad NUM_PADS-1 MSB sits at the top: stream bit k = w_flat[L-1-k].
    always_comb begin
        w_flat = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            w_flat[i*PAD_CTRL_BITS +: PAD_CTRL_BITS] = r_shadow[i];
        end
    end

    assign w_sidx       = K_LAST - r_k;
    assign w_stream_bit = w_flat[w_sidx];

    always_comb begin
        w_rd_data = '0;
        if (int'(cfg_rd_idx) < NUM_PADS) begin
            w_rd_data = r_shadow[cfg_rd_idx];
        end
    end

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_LO;
            S_LO:   if (w_div_tc) w_next = S_HI;
            S_HI: begin
                if (w_div_tc) begin
                    if (!w_last_bit || w_more_pass) w_next = S_LO;
                    else                            w_next = S_LOAD;
                end
            end
            S_LOAD: if (w_div_tc) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sclk  = 1'b0;
        w_sload = 1'b0;
        w_sdo   = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_LO: begin
                w_sdo  = w_stream_bit;
                w_busy = 1'b1;
            end
            S_HI: begin
                w_sclk = 1'b1;
                w_sdo  = w_stream_bit;
                w_busy = 1'b1;
            end
            S_LOAD: begin
                w_sload = 1'b1;
                w_busy  = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Divider reloads on every state entry and counts down to its terminal value.
    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            r_div       <= DIV_LAST;
            r_k         <= '0;
            r_pass      <= 1'b0;
            r_vmode     <= 1'b0;
            r_auto_pend <= (AUTO_LOAD != 0);
        end else begin
            r_auto_pend <= 1'b0;
            if (w_next != r_state) begin
                r_div <= DIV_LAST;
            end else if (!w_div_tc) begin
                r_div <= r_div - 1'b1;
            end
            if (w_accept) begin
                r_k     <= '0;
                r_pass  <= 1'b0;
                r_vmode <= w_accept_verify;
            end else if (r_state == S_HI && w_div_tc) begin
                if (!w_last_bit) begin
                    r_k <= r_k + 1'b1;
                end else if (w_more_pass) begin
                    r_k    <= '0;
                    r_pass <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            r_verify_err <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_accept) begin
            r_verify_err <= 1'b0;
            r_err_cnt    <= '0;
        end else if (r_state == S_LO && w_div_tc && r_pass && (serial_data_in != w_stream_bit)) begin
            r_verify_err <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                r_shadow[i] <= GPIO_DEFAULTS;
            end
        end else if (w_wr_ok) begin
            r_shadow[cfg_wr_idx] <= cfg_wr_data;
        end
    end

    assign cfg_rd_data     = w_rd_data;
    assign busy            = w_busy;
    assign done            = w_done;
    assign verify_err      = r_verify_err;
    assign err_cnt         = r_err_cnt;
    assign serial_clock    = w_sclk;
    assign serial_load     = w_sload;
    assign serial_data_out = w_sdo;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: 3 pads x 12 bits, CLK_DIV=2, no auto-load, with a 36-bit chain model.
module tb_gpio_cfg_loader;

    localparam int NP = 3;
    localparam int PB = 12;
    localparam int CD = 2;
    localparam int L  = NP * PB;

    logic        mclk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [1:0]  cfg_wr_idx = '0;
    logic [11:0] cfg_wr_data = '0;
    logic [1:0]  cfg_rd_idx = '0;
    logic [11:0] cfg_rd_data;
    logic        start = 1'b0;
    logic        verify = 1'b0;
    logic        busy, done, verify_err;
    logic [7:0]  err_cnt;
    logic        serial_clock, serial_load, serial_data_out, serial_data_in;

    int n_checks = 0;
    int n_pass = 0;

    bit          exp_q[$];
    bit          exp_bit;
    int          sc_edges = 0;
    int          load_cycles = 0;
    int          overlap_cnt = 0;
    int          done_seen = 0;
    logic        prev_sc = 1'b0;
    logic [35:0] chain = '0;
    logic [35:0] latched = '0;
    bit          stuck_en = 1'b0;

    gpio_cfg_loader #(
        .NUM_PADS(NP), .PAD_CTRL_BITS(PB), .GPIO_DEFAULTS(12'hC00),
        .CLK_DIV(CD), .AUTO_LOAD(0)
    ) dut (
        .mclk(mclk), .resetn(resetn),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
        .cfg_rd_idx(cfg_rd_idx), .cfg_rd_data(cfg_rd_data),
        .start(start), .verify(verify), .busy(busy), .done(done),
        .verify_err(verify_err), .err_cnt(err_cnt),
        .serial_clock(serial_clock), .serial_load(serial_load),
        .serial_data_out(serial_data_out), .serial_data_in(serial_data_in)
    );

    always #5 mclk = ~mclk;

    // Chain model; the stuck fault forces the returned value of stream position 5 to 1.
    always @(posedge serial_clock) chain <= {chain[34:0], serial_data_out};
    always @(posedge serial_load)  latched <= chain;
    assign serial_data_in = chain[35] | (stuck_en && ((sc_edges % L) == 5));

    // Scoreboard consumer: each rising serial_clock pops one expected stream bit.
    always @(negedge mclk) begin
        if (serial_clock && !prev_sc) begin
            sc_edges++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_bit: unexpected edge %0d, nothing queued", sc_edges);
            end else begin
                exp_bit = exp_q.pop_front();
                if (serial_data_out !== exp_bit)
                    $display("FAIL stream_bit: edge %0d got %b expected %b", sc_edges, serial_data_out, exp_bit);
                else
                    n_pass++;
            end
        end
        if (serial_load) load_cycles++;
        if (serial_load && serial_clock) overlap_cnt++;
        if (done) done_seen++;
        prev_sc = serial_clock;
    end

    task automatic clear_mon();
        exp_q.delete();
        sc_edges = 0;
        load_cycles = 0;
        overlap_cnt = 0;
        done_seen = 0;
    endtask

    task automatic push_stream(input logic [11:0] w2, input logic [11:0] w1, input logic [11:0] w0, input int passes);
        logic [35:0] s;
        s = {w2, w1, w0};
        for (int p = 0; p < passes; p++)
            for (int b = 35; b >= 0; b--)
                exp_q.push_back(s[b]);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [11:0] data);
        @(negedge mclk);
        cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_data = data;
        @(negedge mclk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic chk_rd(input logic [1:0] idx, input logic [11:0] exp, input string tag);
        cfg_rd_idx = idx;
        #1;
        n_checks++;
        if (cfg_rd_data !== exp)
            $display("FAIL %s: rd[%0d] got %h expected %h", tag, idx, cfg_rd_data, exp);
        else
            n_pass++;
    endtask

    // Starts a load; optionally pokes start+write (idx1 <= ABC) at poke_cyc while busy.
    task automatic run_load(input logic v, input int exp_lat, input int poke_cyc, input string tag);
        int cyc;
        @(negedge mclk);
        start = 1'b1; verify = v;
        @(negedge mclk);
        start = 1'b0; verify = 1'b0;
        cyc = 1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL %s_busy_rise: busy got %b expected 1", tag, busy);
        else n_pass++;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge mclk);
            cyc++;
            if (cyc == poke_cyc) begin
                start = 1'b1; cfg_wr_en = 1'b1; cfg_wr_idx = 2'd1; cfg_wr_data = 12'hABC;
            end else begin
                start = 1'b0; cfg_wr_en = 1'b0;
            end
        end
        start = 1'b0; cfg_wr_en = 1'b0;
        n_checks++;
        if (cyc !== exp_lat) $display("FAIL %s_latency: done at cycle %0d expected %0d", tag, cyc, exp_lat);
        else n_pass++;
        @(negedge mclk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_post_done: done=%b busy=%b expected 0/0", tag, done, busy);
        else n_pass++;
    endtask

    task automatic chk_shift(input int exp_edges, input string tag);
        n_checks++;
        if (sc_edges !== exp_edges || load_cycles !== CD || overlap_cnt !== 0 || exp_q.size() !== 0)
            $display("FAIL %s_shift: edges=%0d load=%0d overlap=%0d left=%0d expected %0d/%0d/0/0",
                     tag, sc_edges, load_cycles, overlap_cnt, exp_q.size(), exp_edges, CD);
        else n_pass++;
    endtask

    task automatic chk_idle_outputs(input string tag);
        n_checks++;
        if ({serial_clock, serial_load, serial_data_out, busy, done, verify_err} !== 6'b0 || err_cnt !== 8'd0)
            $display("FAIL %s: sclk=%b load=%b sdo=%b busy=%b done=%b verr=%b errcnt=%0d expected all 0",
                     tag, serial_clock, serial_load, serial_data_out, busy, done, verify_err, err_cnt);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        chk_idle_outputs("reset_in");
        repeat (3) @(negedge mclk);
        resetn = 1'b1;
        repeat (3) @(negedge mclk);
        chk_idle_outputs("reset_idle");
        for (int i = 0; i < NP; i++) chk_rd(2'(i), 12'hC00, "reset_shadow");
        chk_rd(2'd3, 12'h000, "rd_out_of_range");
    endtask

    task automatic test_default_load();
        clear_mon();
        push_stream(12'hC00, 12'hC00, 12'hC00, 1);
        run_load(1'b0, 147, 0, "default");
        chk_shift(36, "default");
        n_checks++;
        if (latched !== {12'hC00, 12'hC00, 12'hC00}) $display("FAIL default_chain: got %h expected c00c00c00", latched);
        else n_pass++;
    endtask

    task automatic test_pattern_load();
        wr(2'd0, 12'h001);
        wr(2'd1, 12'h0A5);
        wr(2'd2, 12'hFFF);
        wr(2'd3, 12'h777);
        chk_rd(2'd0, 12'h001, "pattern_rd");
        chk_rd(2'd1, 12'h0A5, "pattern_rd");
        chk_rd(2'd2, 12'hFFF, "pattern_rd");
        chk_rd(2'd3, 12'h000, "pattern_rd_oob");
        clear_mon();
        push_stream(12'hFFF, 12'h0A5, 12'h001, 1);
        run_load(1'b0, 147, 0, "pattern");
        chk_shift(36, "pattern");
        n_checks++;
        if (latched !== {12'hFFF, 12'h0A5, 12'h001}) $display("FAIL pattern_chain: got %h expected fff0a5001", latched);
        else n_pass++;
    endtask

    task automatic test_verify_clean();
        clear_mon();
        push_stream(12'hFFF, 12'h0A5, 12'h001, 2);
        run_load(1'b1, 291, 0, "verify_clean");
        chk_shift(72, "verify_clean");
        n_checks++;
        if (verify_err !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL verify_clean_err: verr=%b errcnt=%0d expected 0/0", verify_err, err_cnt);
        else n_pass++;
    endtask

    task automatic test_verify_stuck();
        for (int i = 0; i < NP; i++) wr(2'(i), 12'h000);
        stuck_en = 1'b1;
        clear_mon();
        push_stream(12'h000, 12'h000, 12'h000, 2);
        run_load(1'b1, 291, 0, "verify_stuck");
        chk_shift(72, "verify_stuck");
        n_checks++;
        if (verify_err !== 1'b1 || err_cnt !== 8'd1)
            $display("FAIL verify_stuck_err: verr=%b errcnt=%0d expected 1/1", verify_err, err_cnt);
        else n_pass++;
        repeat (5) @(negedge mclk);
        n_checks++;
        if (verify_err !== 1'b1 || err_cnt !== 8'd1)
            $display("FAIL verify_stuck_hold: verr=%b errcnt=%0d expected 1/1", verify_err, err_cnt);
        else n_pass++;
        stuck_en = 1'b0;
    endtask

    task automatic test_busy_ignore();
        wr(2'd1, 12'h123);
        clear_mon();
        push_stream(12'h000, 12'h123, 12'h000, 1);
        run_load(1'b0, 147, 40, "busy_ignore");
        chk_shift(36, "busy_ignore");
        chk_rd(2'd1, 12'h123, "busy_write_dropped");
        n_checks++;
        if (verify_err !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL start_clears_err: verr=%b errcnt=%0d expected 0/0", verify_err, err_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        clear_mon();
        push_stream(12'h000, 12'h123, 12'h000, 1);
        @(negedge mclk);
        start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        repeat (49) @(negedge mclk);
        resetn = 1'b0;
        #1;
        chk_idle_outputs("abort_outputs");
        for (int i = 0; i < NP; i++) chk_rd(2'(i), 12'hC00, "abort_shadow");
        repeat (5) @(negedge mclk);
        resetn = 1'b1;
        repeat (10) @(negedge mclk);
        n_checks++;
        if (done_seen !== 0 || busy !== 1'b0) $display("FAIL abort_no_done: done pulses=%0d busy=%b expected 0/0", done_seen, busy);
        else n_pass++;
        clear_mon();
        push_stream(12'hC00, 12'hC00, 12'hC00, 1);
        run_load(1'b0, 147, 0, "after_abort");
        chk_shift(36, "after_abort");
    endtask

    initial begin
        test_reset();
        test_default_load();
        test_pattern_load();
        test_verify_clean();
        test_verify_stuck();
        test_busy_ignore();
        test_reset_abort();
        repeat (2) @(negedge mclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
